// File: rtl/time_pkg.sv
// ============================================================================
// Module      : time_pkg
// Description : Shared constants for the time-setting key controller: key
//               indices, add-FSM state encoding and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_pkg;

    // Bit positions of the push-buttons within key_n
    localparam int KEY_MODE = 0;
    localparam int KEY_SEL  = 1;
    localparam int KEY_ADD  = 2;
    localparam int KEY_CLR  = 3;

    // Add auto-repeat state machine encoding
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_PULSE       = 2'd1;
    localparam logic [1:0] ST_HOLD_DELAY  = 2'd2;
    localparam logic [1:0] ST_HOLD_REPEAT = 2'd3;

    // Bits needed to count 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/time_key_ctrl_if.sv
// ============================================================================
// Module      : time_key_ctrl_if
// Description : Key inputs and time_float control outputs of the key
//               controller. The slave side is the controller itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface time_key_ctrl_if;
    logic [3:0] key_n;
    logic       adjust;
    logic [3:0] select;
    logic       add;
    logic       clr;

    modport master (output key_n, input adjust, input select, input add, input clr);
    modport slave  (input key_n, output adjust, output select, output add, output clr);
endinterface

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Synchronizes one active-low key, debounces it and emits a
//               single-cycle press event. After reset the key is disarmed
//               until a stable release has been seen, so a key held through
//               reset never produces a press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
    import time_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  wire logic CLOCK_50,
    input  wire logic rst,
    input  wire logic key_n,
    output logic      pressed,
    output logic      press_evt
);

    localparam int             CW     = cnt_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  c_last = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_armed;
    logic          r_pressed;
    logic          r_evt;
    logic          w_level;
    logic          w_counting;

    assign w_level    = ~r_sync2;
    // Armed: count while the level disagrees with the accepted state.
    // Disarmed: count while the key is released, to arm once stable.
    assign w_counting = r_armed ? (w_level != r_pressed) : ~w_level;

    // Two-flop synchronizer, idles at the released level
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter, accepted level, arming flag and press event
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_armed   <= 1'b0;
            r_pressed <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_evt <= 1'b0;
            if (!w_counting) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_cnt <= '0;
                if (r_armed) begin
                    r_pressed <= w_level;
                    r_evt     <= w_level;
                end else begin
                    r_armed <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pressed   = r_pressed;
    assign press_evt = r_evt;

endmodule

`default_nettype wire

// File: rtl/time_key_ctrl.sv
// ============================================================================
// Module      : time_key_ctrl
// Description : Turns four DE2 push-buttons into time_float controls: run/set
//               mode, digit select, add pulses with auto-repeat, clear pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_key_ctrl
    import time_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 1_000_000,
    parameter int PULSE_CYC        = 16,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC  = 5_000_000
) (
    input  wire logic      CLOCK_50,
    input  wire logic      rst,
    time_key_ctrl_if.slave bus
);

    localparam int PW   = cnt_w(PULSE_CYC);
    localparam int TMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int TW   = cnt_w(TMAX);
    localparam logic [PW-1:0] c_pulse_last = PW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] c_delay_last = TW'(REPEAT_DELAY_CYC - 1);
    localparam logic [TW-1:0] c_rate_last  = TW'(REPEAT_RATE_CYC - 1);
    localparam logic [TW-1:0] c_tcnt_sat   = TW'(TMAX - 1);

    logic [3:0]    w_pressed;
    logic [3:0]    w_evt;
    logic          w_unused_pressed;

    logic          r_adjust, r_add, r_clr, r_rep;
    logic          r_mode_pend, r_clr_pend, r_add_pend;
    logic [3:0]    r_select;
    logic [1:0]    r_state;
    logic [PW-1:0] r_pcnt, r_ccnt;
    logic [TW-1:0] r_tcnt;

    logic          w_add_busy, w_clr_busy, w_clr_start, w_clr_next;
    logic          w_add_start, w_add_pend_nxt, w_rep_nxt, w_timeout;
    logic          w_mode_req, w_mode_go;
    logic [1:0]    w_state_nxt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
                .CLOCK_50 (CLOCK_50),
                .rst      (rst),
                .key_n    (bus.key_n[gi]),
                .pressed  (w_pressed[gi]),
                .press_evt(w_evt[gi])
            );
        end
    endgenerate

    // Only the add key's held level drives behaviour (auto-repeat)
    assign w_unused_pressed = ^{w_pressed[KEY_MODE], w_pressed[KEY_SEL], w_pressed[KEY_CLR]};

    // A running pulse stays high next cycle unless this is its last cycle
    assign w_add_busy  = r_add && (r_pcnt != c_pulse_last);
    assign w_clr_busy  = r_clr && (r_ccnt != c_pulse_last);
    // Clear waits for a running add pulse to finish; it never truncates it
    assign w_clr_start = !r_adjust && !r_clr && !w_add_busy && (w_evt[KEY_CLR] || r_clr_pend);
    assign w_clr_next  = w_clr_start || w_clr_busy;
    assign w_timeout   = (r_state == ST_HOLD_REPEAT) ? (r_tcnt >= c_rate_last)
                                                     : (r_tcnt >= c_delay_last);

    // Add FSM next state; every entry into PULSE yields to an active clear
    always_comb begin
        w_state_nxt    = r_state;
        w_add_start    = 1'b0;
        w_add_pend_nxt = r_add_pend;
        w_rep_nxt      = r_rep;
        case (r_state)
            ST_IDLE: begin
                if (r_adjust) begin
                    w_add_pend_nxt = 1'b0;
                end else if ((w_evt[KEY_ADD] && !w_evt[KEY_CLR]) || r_add_pend) begin
                    if (w_clr_next) begin
                        w_add_pend_nxt = 1'b1;
                    end else begin
                        w_add_start    = 1'b1;
                        w_add_pend_nxt = 1'b0;
                        w_rep_nxt      = 1'b0;
                    end
                end
            end
            ST_PULSE: begin
                if (r_pcnt == c_pulse_last) begin
                    if (!w_pressed[KEY_ADD])
                        w_state_nxt = ST_IDLE;
                    else
                        w_state_nxt = r_rep ? ST_HOLD_REPEAT : ST_HOLD_DELAY;
                end
            end
            default: begin
                if (r_adjust || !w_pressed[KEY_ADD]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout && !w_clr_next) begin
                    w_add_start = 1'b1;
                    w_rep_nxt   = 1'b1;
                end
            end
        endcase
        if (w_add_start)
            w_state_nxt = ST_PULSE;
    end

    // Mode toggles only when no pulse is high in the coming cycle
    assign w_mode_req = w_evt[KEY_MODE] || r_mode_pend;
    assign w_mode_go  = w_mode_req && !w_clr_next && !w_add_start && !w_add_busy;

    // Add FSM state, pulse counter and time-since-pulse-start counter
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_add      <= 1'b0;
            r_pcnt     <= '0;
            r_tcnt     <= '0;
            r_rep      <= 1'b0;
            r_add_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_add      <= w_add_start || w_add_busy;
            r_rep      <= w_rep_nxt;
            r_add_pend <= w_add_pend_nxt;
            if (w_add_start)
                r_pcnt <= '0;
            else if (r_add)
                r_pcnt <= r_pcnt + 1'b1;
            if (w_add_start)
                r_tcnt <= '0;
            else if (r_tcnt < c_tcnt_sat)
                r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Clear pulse generation with a pending flag for presses during add
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_clr      <= 1'b0;
            r_ccnt     <= '0;
            r_clr_pend <= 1'b0;
        end else begin
            r_clr <= w_clr_next;
            if (w_clr_start)
                r_ccnt <= '0;
            else if (r_clr)
                r_ccnt <= r_ccnt + 1'b1;
            if (r_adjust || w_clr_start)
                r_clr_pend <= 1'b0;
            else if (w_evt[KEY_CLR])
                r_clr_pend <= 1'b1;
        end
    end

    // Mode toggle with deferral, and digit select stepping in set mode
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_adjust    <= 1'b1;
            r_mode_pend <= 1'b0;
            r_select    <= 4'd0;
        end else begin
            if (w_mode_go)
                r_adjust <= ~r_adjust;
            r_mode_pend <= w_mode_req && !w_mode_go;
            if (w_evt[KEY_SEL] && !r_adjust)
                r_select <= r_select + 4'd1;
        end
    end

    assign bus.adjust = r_adjust;
    assign bus.select = r_select;
    assign bus.add    = r_add;
    assign bus.clr    = r_clr;

endmodule

`default_nettype wire

// File: doc/time_key_ctrl.md
TIME_KEY_CTRL -- requirements
Module: time_key_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 1_000_000, the stable-level cycles needed to accept a key change (20 ms at 50 MHz).
REQ-002 SHALL have parameter PULSE_CYC, default 16, the high-time in cycles of every add/clr pulse.
REQ-003 SHALL have parameter REPEAT_DELAY_CYC, default 25_000_000, the hold time before add auto-repeat starts (500 ms).
REQ-004 SHALL have parameter REPEAT_RATE_CYC, default 5_000_000, the auto-repeat period (100 ms).
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port key_n, input, 4 bits: raw DE2 push-buttons, active-low, asynchronous. [0]=mode, [1]=select, [2]=add, [3]=clr.
REQ-008 SHALL have port adjust, output, 1 bit: 1 = clock-driven run, 0 = manual set. Feeds time_float.adjust.
REQ-009 SHALL have port select, output, 4 bits: digit index 0..15 using the time_float digit map (0 = ms low ... 15 = year thousands).
REQ-010 SHALL have port add, output, 1 bit: active-high increment pulse.
REQ-011 SHALL have port clr, output, 1 bit: active-high digit-clear pulse.

Function
REQ-012 SHALL pass each key_n bit through a 2-flop synchronizer, then a debouncer; a key is accepted as pressed or released only after its synchronized level holds for DEBOUNCE_CYC consecutive cycles.
REQ-013 SHALL generate one single-cycle press event per key on each debounced 1->0 transition of key_n; releases generate no event.
REQ-014 SHALL toggle adjust on a mode press, but only while neither add nor clr is high; a mode press during a pulse SHALL be held pending and applied in the cycle after that pulse ends.
REQ-015 SHALL, on a select press while adjust=0, set select to (select+1) mod 16; 15 wraps to 0.
REQ-016 SHALL ignore select, add and clr presses while adjust=1; add and clr SHALL stay 0.
REQ-017 SHALL keep select unchanged across mode toggles.
REQ-018 SHALL, on a clr press while adjust=0, drive clr=1 for exactly PULSE_CYC cycles, starting in the cycle after the event.
REQ-019 SHALL run the add FSM with states IDLE, PULSE, HOLD_DELAY, HOLD_REPEAT:
  - IDLE -> PULSE on an add press (adjust=0).
  - PULSE: add=1 for PULSE_CYC cycles, then HOLD_DELAY if the key is still pressed, else IDLE.
  - HOLD_DELAY: after REPEAT_DELAY_CYC cycles measured from pulse start, -> PULSE.
  - HOLD_REPEAT: after REPEAT_RATE_CYC cycles measured from pulse start, -> PULSE.
  - A second or later PULSE entry returns to HOLD_REPEAT, not HOLD_DELAY.
  - A debounced release in HOLD_DELAY or HOLD_REPEAT -> IDLE.
REQ-020 SHALL give clr priority over add: a clr event during IDLE of the add FSM, or in the same cycle as an add event, suppresses that add. While clr=1, add FSM transitions into PULSE are deferred until clr falls.
REQ-021 SHALL never truncate an add or clr pulse that has started; adjust changes only between pulses.
REQ-022 SHALL guarantee add and clr are never high in the same cycle.
REQ-023 SHALL drive all outputs directly from flops, with no combinational paths from key_n.

Reset
REQ-024 SHALL on rst=1 asynchronously set adjust=1, select=0, add=0, clr=0, add FSM=IDLE, all debouncers to "released", and clear all counters and pending flags.
REQ-025 SHALL, when rst is asserted mid-pulse, drop add/clr immediately; after rst deasserts, a key already held SHALL NOT create a press event until it is released and pressed again.

Structure
REQ-026 SHALL place the key index constants (KEY_MODE=0, KEY_SEL=1, KEY_ADD=2, KEY_CLR=3) and the add FSM state encoding in shared package time_pkg.
REQ-027 SHALL implement the synchronizer, debouncer and press-event logic as one sub-module key_debounce (ports: CLOCK_50, rst, key_n, pressed, press_evt; parameter DEBOUNCE_CYC), instantiated 4 times.

Verification
REQ-028 SHALL include these directed scenarios, run with DEBOUNCE_CYC=8, PULSE_CYC=4, REPEAT_DELAY_CYC=40, REPEAT_RATE_CYC=10:
  - Reset, then key_n[0] low with 3-cycle bounces, then stable for 8 cycles -> exactly one adjust toggle, 1->0; bounces produce no event.
  - adjust=0, select=15, one select press -> select=0; with adjust=1, a select press -> select unchanged.
  - adjust=0, add held 100 cycles -> first add pulse 4 cycles wide, second pulse starts 40 cycles after the first, then pulses every 10 cycles; release -> no further pulses.
  - adjust=0, add and clr pressed in the same cycle -> a single 4-cycle clr pulse and zero add pulses.
  - Mode press during an add pulse -> the add pulse completes its full 4 cycles, then adjust=1 on the next cycle.
  - rst asserted during a clr pulse -> clr=0 and adjust=1 in the same cycle; clr still held after rst release -> no pulse until it is re-pressed.
